// File: rtl/fp_wb_status.sv
// Writeback/status stage behind the FP ALU: 2-entry writeback FIFO toward the
// FP register file plus the architectural FCSR (RM, sticky flags, enables, cause, FCC) and trap pulse.
module fp_wb_status #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_result,
    input  logic        in_dbz,
    input  logic        in_qnan,
    input  logic        in_snan,
    input  logic        in_inexact,
    input  logic        in_underflow,
    input  logic        in_overflow,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic        fcsr_we,
    input  logic [31:0] fcsr_wdata,
    output logic [31:0] fcsr,
    output logic [1:0]  rounding_mode,
    output logic        fp_trap
);

    localparam logic [1:0] COUNT_FULL  = 2'd2;
    localparam logic [1:0] COUNT_EMPTY = 2'd0;

    // Exception vector in FCSR field order {V,Z,O,U,I}.
    function automatic logic [4:0] flag_vec(
        input logic dbz,
        input logic qnan,
        input logic snan,
        input logic overflow,
        input logic underflow,
        input logic inexact
    );
        return {qnan | snan, dbz, overflow, underflow, inexact};
    endfunction

    logic [1:0]  rm_r;
    logic [4:0]  flags_r;
    logic [4:0]  enables_r;
    logic [4:0]  cause_r;
    logic        fcc_r;
    logic        trap_r;
    logic [1:0]  count_r;
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [4:0]  addr_mem_r [DEPTH];
    logic [31:0] data_mem_r [DEPTH];

    logic [4:0]  e_s;
    logic        accept_s;
    logic        trap_s;
    logic        is_cmp_s;
    logic        push_s;
    logic        pop_s;
    logic [1:0]  count_nxt_s;

    assign e_s      = flag_vec(in_dbz, in_qnan, in_snan, in_overflow, in_underflow, in_inexact);
    assign in_ready = (count_r != COUNT_FULL) && !fcsr_we;
    assign wb_valid = (count_r != COUNT_EMPTY);
    assign wb_addr  = addr_mem_r[rd_ptr_r];
    assign wb_data  = data_mem_r[rd_ptr_r];
    assign fcsr     = {8'b0, fcc_r, 6'b0, cause_r, enables_r, flags_r, rm_r};
    assign rounding_mode = rm_r;
    assign fp_trap  = trap_r;

    // Decode the accept into trap / compare / push actions.
    always_comb begin
        accept_s = in_valid && in_ready;
        trap_s   = 1'b0;
        is_cmp_s = 1'b0;
        push_s   = 1'b0;
        pop_s    = wb_valid && wb_ready;
        case (in_op)
            5'd22, 5'd23: is_cmp_s = 1'b1;
            default:      is_cmp_s = 1'b0;
        endcase
        if (accept_s) begin
            trap_s = ((e_s & enables_r) != 5'd0);
            push_s = !trap_s && !is_cmp_s;
        end else begin
            trap_s = 1'b0;
            push_s = 1'b0;
        end
    end

    // Occupancy update; push is already excluded when full.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FCSR fields and the trap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rm_r      <= 2'd0;
            flags_r   <= 5'd0;
            enables_r <= 5'd0;
            cause_r   <= 5'd0;
            fcc_r     <= 1'b0;
            trap_r    <= 1'b0;
        end else begin
            trap_r <= trap_s;
            if (fcsr_we) begin
                rm_r      <= fcsr_wdata[1:0];
                flags_r   <= fcsr_wdata[6:2];
                enables_r <= fcsr_wdata[11:7];
                cause_r   <= fcsr_wdata[16:12];
                fcc_r     <= fcsr_wdata[23];
            end else if (accept_s) begin
                cause_r <= e_s;
                if (!trap_s) begin
                    flags_r <= flags_r | e_s;
                    if (is_cmp_s) begin
                        fcc_r <= in_result[0];
                    end
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else if (push_s) begin
            addr_mem_r[wr_ptr_r] <= in_dest;
            data_mem_r[wr_ptr_r] <= in_result;
        end
    end

endmodule

// File: tb/tb_fp_wb_status.sv
// Directed self-checking bench for fp_wb_status: reset, sticky flags, trap,
// compare/FCC, FIFO backpressure with reset while full, and CPU FCSR write.
module tb_fp_wb_status;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        in_dbz, in_qnan, in_snan, in_inexact, in_underflow, in_overflow;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fcsr_we;
    logic [31:0] fcsr_wdata;
    logic [31:0] fcsr;
    logic [1:0]  rounding_mode;
    logic        fp_trap;

    int pass_cnt = 0;
    int total_cnt = 0;

    fp_wb_status #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dest(in_dest), .in_result(in_result),
        .in_dbz(in_dbz), .in_qnan(in_qnan), .in_snan(in_snan),
        .in_inexact(in_inexact), .in_underflow(in_underflow), .in_overflow(in_overflow),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .fcsr_we(fcsr_we), .fcsr_wdata(fcsr_wdata),
        .fcsr(fcsr), .rounding_mode(rounding_mode), .fp_trap(fp_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags = {V(qnan),Z,O,U,I}
    task automatic offer(input logic [4:0] op, input logic [4:0] dest,
                         input logic [31:0] res, input logic [4:0] flags);
        in_valid     = 1'b1;
        in_op        = op;
        in_dest      = dest;
        in_result    = res;
        in_qnan      = flags[4];
        in_dbz       = flags[3];
        in_overflow  = flags[2];
        in_underflow = flags[1];
        in_inexact   = flags[0];
        in_snan      = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_dbz = 1'b0; in_qnan = 1'b0; in_snan = 1'b0;
        in_inexact = 1'b0; in_underflow = 1'b0; in_overflow = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_op = 5'd0; in_dest = 5'd0; in_result = 32'd0;
        idle();
        wb_ready = 1'b0;
        fcsr_we = 1'b0;
        fcsr_wdata = 32'd0;
        step();
        step();
        check("reset_fcsr", fcsr, 32'h0);
        check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("reset_trap", {31'b0, fp_trap}, 32'd0);
        rst_n = 1'b1;

        // Basic writeback
        wb_ready = 1'b1;
        offer(5'd16, 5'd3, 32'h3F80_0000, 5'b00000);
        check("ready_idle", {31'b0, in_ready}, 32'd1);
        step();
        idle();
        check("wb_valid_1", {31'b0, wb_valid}, 32'd1);
        check("wb_addr_1", {27'b0, wb_addr}, 32'd3);
        check("wb_data_1", wb_data, 32'h3F80_0000);
        check("fcsr_clean", fcsr, 32'h0);
        step();
        check("wb_drained", {31'b0, wb_valid}, 32'd0);

        // Sticky flags and cause
        offer(5'd17, 5'd1, 32'h1111_1111, 5'b00001);
        step();
        offer(5'd18, 5'd2, 32'h2222_2222, 5'b00100);
        step();
        idle();
        check("flags_sticky", {27'b0, fcsr[6:2]}, 32'h05);
        check("cause_last", {27'b0, fcsr[16:12]}, 32'h04);
        offer(5'd16, 5'd4, 32'h4444_4444, 5'b00000);
        step();
        idle();
        check("fcsr_after_clean", fcsr, 32'h0000_0014);
        step();
        step();

        // Trap with Z enabled
        fcsr_we = 1'b1;
        fcsr_wdata = 32'h0000_0400;
        step();
        fcsr_we = 1'b0;
        check("fcsr_write_en", fcsr, 32'h0000_0400);
        offer(5'd19, 5'd6, 32'h7F80_0000, 5'b01000);
        step();
        idle();
        check("trap_pulse", {31'b0, fp_trap}, 32'd1);
        check("trap_fcsr", fcsr, 32'h0000_8400);
        check("trap_no_wb", {31'b0, wb_valid}, 32'd0);
        step();
        check("trap_end", {31'b0, fp_trap}, 32'd0);
        check("trap_still_no_wb", {31'b0, wb_valid}, 32'd0);

        // Non-enabled flag while Z enabled: no trap, sticky update
        offer(5'd16, 5'd8, 32'h8888_8888, 5'b00010);
        step();
        idle();
        check("noentrap", {31'b0, fp_trap}, 32'd0);
        check("noentrap_fcsr", fcsr, 32'h0000_2408);
        check("noentrap_wb", {27'b0, wb_addr}, 32'd8);
        step();

        // Compare ops set FCC, no writeback
        offer(5'd23, 5'd9, 32'h0000_0001, 5'b00000);
        step();
        idle();
        check("fcc_set", {31'b0, fcsr[23]}, 32'd1);
        check("cmp_no_wb", {31'b0, wb_valid}, 32'd0);
        offer(5'd22, 5'd9, 32'h0000_0000, 5'b00000);
        step();
        idle();
        check("fcc_clr", {31'b0, fcsr[23]}, 32'd0);

        // Backpressure
        wb_ready = 1'b0;
        offer(5'd16, 5'd10, 32'hAAAA_0001, 5'b00000);
        step();
        offer(5'd16, 5'd11, 32'hBBBB_0002, 5'b00000);
        step();
        offer(5'd16, 5'd12, 32'hCCCC_0003, 5'b00000);
        check("full_not_ready", {31'b0, in_ready}, 32'd0);
        step();
        check("full_hold_ready", {31'b0, in_ready}, 32'd0);
        check("head_stable_addr", {27'b0, wb_addr}, 32'd10);
        check("head_stable_data", wb_data, 32'hAAAA_0001);
        wb_ready = 1'b1;
        step();
        check("pop_a_head_b", wb_data, 32'hBBBB_0002);
        check("ready_after_pop", {31'b0, in_ready}, 32'd1);
        step();
        idle();
        check("head_c_data", wb_data, 32'hCCCC_0003);
        check("head_c_addr", {27'b0, wb_addr}, 32'd12);
        step();
        check("drained_abc", {31'b0, wb_valid}, 32'd0);

        // Reset while full
        wb_ready = 1'b0;
        offer(5'd16, 5'd13, 32'hDDDD_0004, 5'b00000);
        step();
        offer(5'd16, 5'd14, 32'hEEEE_0005, 5'b00000);
        step();
        idle();
        check("full_again", {30'b0, wb_valid, in_ready}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, wb_valid}, 32'd0);
        check("async_rst_data", wb_data, 32'h0);
        check("async_rst_fcsr", fcsr, 32'h0);
        step();
        rst_n = 1'b1;
        wb_ready = 1'b1;

        // CPU write blocks accept
        fcsr_we = 1'b1;
        fcsr_wdata = 32'hFFFF_FFFF;
        offer(5'd16, 5'd7, 32'h7777_7777, 5'b00001);
        #1;
        check("we_blocks_ready", {31'b0, in_ready}, 32'd0);
        step();
        fcsr_we = 1'b0;
        idle();
        check("we_masked", fcsr, 32'h0081_FFFF);
        check("we_no_wb", {31'b0, wb_valid}, 32'd0);
        check("rm_out", {30'b0, rounding_mode}, 32'd3);
        check("we_no_trap", {31'b0, fp_trap}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
